// File: rtl/dm_access_pkg.sv
// dm_access_pkg: shared definitions for the M-stage data-memory bridge.
//   - dm_op_e      : load/store op codes (raw 4-bit codes 9..15 decode to DM_NONE)
//   - decode_op    : raw m_op -> dm_op_e
//   - is_load      : op reads memory into W
//   - is_store     : op writes memory
//   - is_misaligned: address not naturally aligned for the op's access size
//   - BE_*         : byte-enable patterns, lane 0 = bits 7:0
package dm_access_pkg;

  typedef enum logic [3:0] {
    DM_NONE = 4'd0,
    DM_LW   = 4'd1,
    DM_LH   = 4'd2,
    DM_LHU  = 4'd3,
    DM_LB   = 4'd4,
    DM_LBU  = 4'd5,
    DM_SW   = 4'd6,
    DM_SH   = 4'd7,
    DM_SB   = 4'd8
  } dm_op_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic dm_op_e decode_op(input logic [3:0] raw);
    return (raw > 4'd8) ? DM_NONE : dm_op_e'(raw);
  endfunction

  function automatic logic is_load(input dm_op_e op);
    return (op == DM_LW) || (op == DM_LH) || (op == DM_LHU) ||
           (op == DM_LB) || (op == DM_LBU);
  endfunction

  function automatic logic is_store(input dm_op_e op);
    return (op == DM_SW) || (op == DM_SH) || (op == DM_SB);
  endfunction

  function automatic logic is_misaligned(input dm_op_e op, input logic [1:0] lo);
    logic word_op;
    logic half_op;
    word_op = (op == DM_LW) || (op == DM_SW);
    half_op = (op == DM_LH) || (op == DM_LHU) || (op == DM_SH);
    return (word_op && (lo != 2'b00)) || (half_op && lo[0]);
  endfunction

endpackage

// File: rtl/dm_access_load_ext.sv
// load_ext: combinational load-data extraction.
// Selects the half/byte lane addressed by addr[1:0] out of the memory word and
// sign- or zero-extends it to 32 bits. Word loads pass the whole word; any
// non-load op yields 0. Half selection looks only at addr[1].
//   op   in  4  : load op code (dm_op_e encoding)
//   addr in  2  : byte offset within the word
//   word in  32 : memory read word
//   data out 32 : extended load result
module load_ext
  import dm_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = addr[1] ? word[31:16] : word[15:0];
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  always_comb begin
    data = '0;
    case (decode_op(op))
      DM_LW:   data = word;
      DM_LH:   data = {{16{half[15]}}, half};
      DM_LHU:  data = {16'h0000, half};
      DM_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      DM_LBU:  data = {24'h000000, byte_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dm_access.sv
// dm_access: memory-stage data-memory bridge for the pipelined MIPS core.
// Store path (combinational from M): word-aligned address, byte enables and
// lane-replicated store data. Load path: {op, addr[1:0]} registered into W,
// then lane-selected and extended from dm_rdata one cycle later. A hold
// buffer keeps the W load result stable while stalled.
// Optional feature macro: DM_MISALIGN_CHECK_EN (misaligned access detection;
// flagged stores are suppressed and flagged loads become NONE).
//   clk       in  1  : rising-edge clock
//   reset     in  1  : synchronous, active-high
//   stall     in  1  : freeze W state, suppress memory write
//   m_op      in  4  : M-stage op code
//   m_addr    in  32 : byte address
//   m_wdata   in  32 : store source value
//   dm_addr   out 32 : word-aligned memory address
//   dm_byteen out 4  : per-lane write enable
//   dm_wdata  out 32 : lane-replicated store data
//   dm_rdata  in  32 : memory read word (valid one cycle after address)
//   w_rdata   out 32 : extended load result
//   w_valid   out 1  : load result present in W
//   misalign  out 1  : misaligned access flag
module dm_access
  import dm_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [3:0]  m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_byteen,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic [31:0] w_rdata,
  output logic        w_valid,
  output logic        misalign
);

  dm_op_e      mop;
  logic        mis;
  logic [3:0]  be;

  dm_op_e      w_op;
  logic [1:0]  w_lo;
  logic        hold_flag;
  logic [31:0] hold_reg;
  logic [31:0] ext_data;

  assign mop = decode_op(m_op);

`ifdef DM_MISALIGN_CHECK_EN
  assign mis = is_misaligned(mop, m_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign misalign = mis;
  assign dm_addr  = {m_addr[31:2], 2'b00};

  always_comb begin
    be       = BE_NONE;
    dm_wdata = m_wdata;
    case (mop)
      DM_SW: be = BE_WORD;
      DM_SH: begin
        be       = m_addr[1] ? BE_HALF_HI : BE_HALF_LO;
        dm_wdata = {2{m_wdata[15:0]}};
      end
      DM_SB: begin
        be       = BE_BYTE0 << m_addr[1:0];
        dm_wdata = {4{m_wdata[7:0]}};
      end
      default: be = BE_NONE;
    endcase
    dm_byteen = (stall || reset || mis) ? BE_NONE : be;
  end

  // Single extractor instance feeds both the live output and hold capture,
  // so the held value is exactly what W was showing on the capture edge.
  load_ext u_load_ext (
    .op   (w_op),
    .addr (w_lo),
    .word (dm_rdata),
    .data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      w_op      <= DM_NONE;
      w_lo      <= 2'b00;
      hold_flag <= 1'b0;
      hold_reg  <= '0;
    end else if (!stall) begin
      w_op      <= (is_load(mop) && !mis) ? mop : DM_NONE;
      w_lo      <= m_addr[1:0];
      hold_flag <= 1'b0;
    end else if (!hold_flag) begin
      hold_reg  <= ext_data;
      hold_flag <= 1'b1;
    end
  end

  assign w_rdata = hold_flag ? hold_reg : ext_data;
  assign w_valid = is_load(w_op);

endmodule

// File: tb/tb_dm_access.sv
module tb_dm_access;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [3:0]  m_op;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] dm_addr;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        misalign;

  int n_vec;
  int n_bad;

  // Reference state: the load sitting in W (0 = none) and the frozen value.
  int          r_op;
  logic [1:0]  r_lo;
  bit          r_holding;
  logic [31:0] r_held;

  dm_access dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .m_op      (m_op),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .dm_addr   (dm_addr),
    .dm_byteen (dm_byteen),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .w_rdata   (w_rdata),
    .w_valid   (w_valid),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int norm_op(input logic [3:0] raw);
    return (int'(raw) > 8) ? 0 : int'(raw);
  endfunction

  function automatic bit op_is_load(input int op);
    return (op >= 1) && (op <= 5);
  endfunction

  function automatic bit mis_of(input int op, input logic [1:0] lo);
`ifdef DM_MISALIGN_CHECK_EN
    if ((op == 1 || op == 6) && lo != 2'b00) return 1'b1;
    if ((op == 2 || op == 3 || op == 7) && lo[0]) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] extract(input int op, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] v;
    int sh;
    case (op)
      1: return w;
      2, 3: begin
        sh = lo[1] ? 16 : 0;
        v  = (w >> sh) & 32'h0000FFFF;
        if (op == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
      end
      4, 5: begin
        sh = int'(lo) * 8;
        v  = (w >> sh) & 32'h000000FF;
        if (op == 4 && v[7]) v = v | 32'hFFFFFF00;
        return v;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_w(input logic [31:0] rd);
    return r_holding ? r_held : extract(r_op, r_lo, rd);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the reference model.
  task automatic compare();
    int          op;
    logic [1:0]  lo;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    bit          emis;
    op   = norm_op(m_op);
    lo   = m_addr[1:0];
    emis = mis_of(op, lo);
    ebe  = 4'b0000;
    ewd  = m_wdata;
    case (op)
      6: ebe = 4'b1111;
      7: begin ebe = lo[1] ? 4'b1100 : 4'b0011; ewd = {m_wdata[15:0], m_wdata[15:0]}; end
      8: begin ebe = 4'(1 << int'(lo)); ewd = {4{m_wdata[7:0]}}; end
      default: ;
    endcase
    if (reset || stall || emis) ebe = 4'b0000;
    chk("dm_addr", dm_addr, m_addr & 32'hFFFFFFFC);
    chk("dm_byteen", {28'h0, dm_byteen}, {28'h0, ebe});
    chk("dm_wdata", dm_wdata, ewd);
    chk("misalign", {31'h0, misalign}, {31'h0, emis});
    chk("w_valid", {31'h0, w_valid}, {31'h0, op_is_load(r_op)});
    chk("w_rdata", w_rdata, model_w(dm_rdata));
  endtask

  task automatic apply(input bit rst, input bit st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    reset    = rst;
    stall    = st;
    m_op     = op;
    m_addr   = a;
    m_wdata  = wd;
    dm_rdata = rd;
    #4;
    compare();
  endtask

  task automatic advance();
    int op;
    @(posedge clk);
    op = norm_op(m_op);
    if (reset) begin
      r_op = 0; r_lo = 2'b00; r_holding = 1'b0; r_held = 32'h0;
    end else if (!stall) begin
      r_op      = (op_is_load(op) && !mis_of(op, m_addr[1:0])) ? op : 0;
      r_lo      = m_addr[1:0];
      r_holding = 1'b0;
    end else if (!r_holding) begin
      r_held    = model_w(dm_rdata);
      r_holding = 1'b1;
    end
    #1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    r_op = 0; r_lo = 2'b00; r_holding = 1'b0; r_held = 32'h0;
    reset = 1'b1; stall = 1'b0; m_op = 4'd0; m_addr = '0; m_wdata = '0; dm_rdata = '0;
    advance();

    // Reset state
    apply(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h12345678);
    chk("rst_w_valid", {31'h0, w_valid}, 32'h0);
    chk("rst_w_rdata", w_rdata, 32'h0);
    chk("rst_byteen", {28'h0, dm_byteen}, 32'h0);
    advance();

    // SB lane 3
    apply(1'b0, 1'b0, 4'd8, 32'h00001003, 32'h000000A5, 32'h0);
    chk("sb_addr", dm_addr, 32'h00001000);
    chk("sb_byteen", {28'h0, dm_byteen}, 32'h8);
    chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    advance();

    // Load extraction chain, each result appears the following cycle
    apply(1'b0, 1'b0, 4'd4, 32'h00002001, 32'h0, 32'h0);            // LB
    advance();
    apply(1'b0, 1'b0, 4'd5, 32'h00002001, 32'h0, 32'h1234F678);     // LBU issued
    chk("lb", w_rdata, 32'hFFFFFFF6);
    chk("lb_valid", {31'h0, w_valid}, 32'h1);
    advance();
    apply(1'b0, 1'b0, 4'd2, 32'h00002002, 32'h0, 32'h1234F678);     // LH issued
    chk("lbu", w_rdata, 32'h000000F6);
    advance();
    apply(1'b0, 1'b0, 4'd3, 32'h00002002, 32'h0, 32'h8001ABCD);     // LHU issued
    chk("lh", w_rdata, 32'hFFFF8001);
    advance();
    apply(1'b0, 1'b0, 4'd1, 32'h00002000, 32'h0, 32'h8001ABCD);     // LW issued
    chk("lhu", w_rdata, 32'h00008001);
    advance();
    apply(1'b0, 1'b0, 4'd4, 32'h00002000, 32'h0, 32'h8001ABCD);     // LB lane 0
    chk("lw", w_rdata, 32'h8001ABCD);
    advance();
    apply(1'b0, 1'b0, 4'd3, 32'h00002000, 32'h0, 32'h8001ABCD);     // LHU low half
    chk("lb_lane0", w_rdata, 32'hFFFFFFCD);
    advance();
    apply(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h8001ABCD);
    chk("lhu_lo", w_rdata, 32'h0000ABCD);
    advance();

    // Store patterns
    apply(1'b0, 1'b0, 4'd6, 32'h00000010, 32'h11223344, 32'h0);
    chk("sw_byteen", {28'h0, dm_byteen}, 32'hF);
    advance();
    apply(1'b0, 1'b0, 4'd7, 32'h00000012, 32'hCAFEBABE, 32'h0);
    chk("sh_hi_wdata", dm_wdata, 32'hBABEBABE);
    chk("sh_hi_byteen", {28'h0, dm_byteen}, 32'hC);
    advance();
    apply(1'b0, 1'b0, 4'd8, 32'h00000011, 32'hCAFEBABE, 32'h0);
    chk("sb1_byteen", {28'h0, dm_byteen}, 32'h2);
    advance();
    apply(1'b0, 1'b0, 4'd7, 32'h00000010, 32'hCAFEBABE, 32'h0);
    advance();
    apply(1'b0, 1'b0, 4'd15, 32'h00000010, 32'hCAFEBABE, 32'h0);    // undefined op
    chk("op15_byteen", {28'h0, dm_byteen}, 32'h0);
    advance();

    // Stall with hold buffer
    apply(1'b0, 1'b0, 4'd1, 32'h00000040, 32'h0, 32'h0);            // LW
    advance();
    apply(1'b0, 1'b1, 4'd8, 32'h00000041, 32'h000000FF, 32'hDEADBEEF);
    chk("stall0", w_rdata, 32'hDEADBEEF);
    chk("stall_sb_byteen", {28'h0, dm_byteen}, 32'h0);
    advance();
    for (int i = 1; i < 3; i++) begin
      apply(1'b0, 1'b1, 4'd8, 32'h00000041, 32'h000000FF, 32'h00000000);
      chk("stall_hold", w_rdata, 32'hDEADBEEF);
      chk("stall_valid", {31'h0, w_valid}, 32'h1);
      advance();
    end
    apply(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h00000000);
    chk("release_hold", w_rdata, 32'hDEADBEEF);
    advance();
    apply(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h00000000);
    chk("after_release_valid", {31'h0, w_valid}, 32'h0);
    advance();

    // Reset mid-load
    apply(1'b0, 1'b0, 4'd1, 32'h00000080, 32'h0, 32'h0);
    advance();
    apply(1'b1, 1'b0, 4'd1, 32'h00000084, 32'h0, 32'h00000055);
    chk("rst_mid_byteen", {28'h0, dm_byteen}, 32'h0);
    advance();
    apply(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h00000077);
    chk("rst_mid_valid", {31'h0, w_valid}, 32'h0);
    chk("rst_mid_rdata", w_rdata, 32'h0);
    advance();

    // Reset together with stall: reset wins, hold state cleared
    apply(1'b0, 1'b0, 4'd4, 32'h00000003, 32'h0, 32'h0);
    advance();
    apply(1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 32'h99000000);
    advance();
    apply(1'b1, 1'b1, 4'd0, 32'h0, 32'h0, 32'h0);
    advance();
    apply(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'hFFFFFFFF);
    chk("rst_stall_rdata", w_rdata, 32'h0);
    advance();

    // Misaligned accesses
    apply(1'b0, 1'b0, 4'd7, 32'h00003001, 32'h00001234, 32'h0);
`ifdef DM_MISALIGN_CHECK_EN
    chk("mis_sh_flag", {31'h0, misalign}, 32'h1);
    chk("mis_sh_byteen", {28'h0, dm_byteen}, 32'h0);
`else
    chk("mis_sh_flag", {31'h0, misalign}, 32'h0);
    chk("mis_sh_byteen", {28'h0, dm_byteen}, 32'h3);
`endif
    advance();
    apply(1'b0, 1'b0, 4'd1, 32'h00003002, 32'h0, 32'h0);
    advance();
    apply(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'hA1B2C3D4);
`ifdef DM_MISALIGN_CHECK_EN
    chk("mis_lw_rdata", w_rdata, 32'h0);
`else
    chk("mis_lw_rdata", w_rdata, 32'hA1B2C3D4);
`endif
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
